// File: rtl/jpeg_rle_expander.sv
// JPEG decoder run-length expander: (run, size, amp) symbols in, 64 zigzag coefficients per block out.
// Optional macro JPEG_DC_PRED_EN adds a DC predictor so the DC output is predictor + diff.
module jpeg_rle_expander (
    input  logic        clk,
    input  logic        rst,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [3:0]  sym_run,
    input  logic [3:0]  sym_size,
    input  logic [10:0] sym_amp,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [11:0] coef_data,
    output logic [5:0]  coef_idx,
    output logic        coef_last,
    output logic        err
);

    typedef enum logic [1:0] {ACCEPT, ZEROS, VALUE, FILL} state_t;

    state_t      state, state_n;
    logic [5:0]  nidx;
    logic [3:0]  zcnt, zcnt_n;
    logic        has_val, has_val_n;
    logic [11:0] val_q, val_n;
    logic        load_en, accept, is_dc, at_last, emit, overflow;
    logic [11:0] emit_data, ext, dc_val;
`ifdef JPEG_DC_PRED_EN
    logic [11:0] dc_pred;
`endif

    // Top-bit test on the masked amplitude decides positive vs. negative range.
    function automatic logic [11:0] extend(input logic [3:0] size, input logic [10:0] amp);
        logic [3:0]  s;
        logic [11:0] mask;
        logic [11:0] a;
        s    = (size > 4'd11) ? 4'd11 : size;
        mask = (12'd1 << s) - 12'd1;
        a    = {1'b0, amp} & mask;
        if ((a & (mask ^ (mask >> 1))) != 12'd0)
            return a;
        return a - mask;
    endfunction

    always_comb begin
        ext = extend(sym_size, sym_amp);
`ifdef JPEG_DC_PRED_EN
        dc_val = dc_pred + ext;
`else
        dc_val = ext;
`endif
        load_en   = !coef_valid || coef_ready;
        sym_ready = (state == ACCEPT) && load_en && !rst;
        accept    = sym_ready && sym_valid;
        is_dc     = (nidx == 6'd0);
        at_last   = (nidx == 6'd63);

        state_n   = state;
        zcnt_n    = zcnt;
        has_val_n = has_val;
        val_n     = val_q;
        emit      = 1'b0;
        emit_data = 12'd0;
        overflow  = 1'b0;

        // The accept cycle already loads the symbol's first coefficient.
        case (state)
            ACCEPT: begin
                if (accept) begin
                    emit = 1'b1;
                    if (is_dc) begin
                        emit_data = dc_val;
                    end else if (sym_run == 4'd0 && sym_size == 4'd0) begin
                        if (!at_last)
                            state_n = FILL;
                    end else if (sym_run == 4'd15 && sym_size == 4'd0) begin
                        if (at_last) begin
                            overflow = 1'b1;
                        end else begin
                            zcnt_n    = 4'd15;
                            has_val_n = 1'b0;
                            state_n   = ZEROS;
                        end
                    end else if (sym_run == 4'd0) begin
                        emit_data = ext;
                    end else begin
                        val_n     = ext;
                        has_val_n = 1'b1;
                        if (at_last)
                            overflow = 1'b1;
                        else if (sym_run == 4'd1)
                            state_n = VALUE;
                        else begin
                            zcnt_n  = sym_run - 4'd1;
                            state_n = ZEROS;
                        end
                    end
                end
            end
            ZEROS: begin
                if (load_en) begin
                    emit   = 1'b1;
                    zcnt_n = zcnt - 4'd1;
                    if (at_last) begin
                        // Anything still pending past index 63 is dropped.
                        overflow = (zcnt != 4'd1) || has_val;
                        state_n  = ACCEPT;
                    end else if (zcnt == 4'd1) begin
                        state_n = has_val ? VALUE : ACCEPT;
                    end
                end
            end
            VALUE: begin
                if (load_en) begin
                    emit      = 1'b1;
                    emit_data = val_q;
                    state_n   = ACCEPT;
                end
            end
            FILL: begin
                if (load_en) begin
                    emit = 1'b1;
                    if (at_last)
                        state_n = ACCEPT;
                end
            end
            default: state_n = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCEPT;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nidx       <= 6'd0;
            zcnt       <= 4'd0;
            has_val    <= 1'b0;
            val_q      <= 12'd0;
            coef_valid <= 1'b0;
            coef_data  <= 12'd0;
            coef_idx   <= 6'd0;
            coef_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            zcnt    <= zcnt_n;
            has_val <= has_val_n;
            val_q   <= val_n;
            if (emit) begin
                coef_valid <= 1'b1;
                coef_data  <= emit_data;
                coef_idx   <= nidx;
                coef_last  <= at_last;
                nidx       <= nidx + 6'd1;
            end else if (coef_ready) begin
                coef_valid <= 1'b0;
            end
            if (overflow)
                err <= 1'b1;
        end
    end

`ifdef JPEG_DC_PRED_EN
    always_ff @(posedge clk) begin
        if (rst)
            dc_pred <= 12'd0;
        else if (accept && is_dc)
            dc_pred <= dc_val;
    end
`endif

endmodule

// File: tb/tb_jpeg_rle_expander.sv
// Self-checking bench for jpeg_rle_expander: directed block scenarios plus random blocks against a symbol-level model.
module tb_jpeg_rle_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_run;
    logic [3:0]  sym_size;
    logic [10:0] sym_amp;
    logic        coef_valid;
    logic        coef_ready;
    logic [11:0] coef_data;
    logic [5:0]  coef_idx;
    logic        coef_last;
    logic        err;

    jpeg_rle_expander dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
        .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_idx(coef_idx), .coef_last(coef_last),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] data;
        logic [5:0]  idx;
        logic        last;
        logic        err;
        int          cyc;
    } coef_t;

    coef_t got_q[$];
    coef_t exp_q[$];
    int    passed = 0;
    int    fails = 0;
    int    total = 0;
    int    cyc = 0;
    bit    bp = 0;
    int    m_pos = 0;
    bit    m_err = 0;
    int    m_pred = 0;

    logic        stall_q = 1'b0;
    logic [11:0] hold_data;
    logic [5:0]  hold_idx;
    logic        hold_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model: the JPEG extend rule in plain integer arithmetic.
    function automatic int m_ext(input int size, input int amp);
        int s;
        int a;
        s = (size > 11) ? 11 : size;
        if (s == 0) return 0;
        a = amp % (1 << s);
        if (a >= (1 << (s - 1))) return a;
        return a - ((1 << s) - 1);
    endfunction

    // Model: expand one symbol into its coefficient list, truncating at the block end.
    function automatic void m_symbol(input int run, input int size, input int amp);
        int    vals[$];
        int    d;
        coef_t c;
        if (m_pos == 0) begin
            d = m_ext(size, amp);
`ifdef JPEG_DC_PRED_EN
            d = (m_pred + d) & 32'hFFF;
            m_pred = d;
`endif
            vals.push_back(d);
        end else if (run == 0 && size == 0) begin
            repeat (64 - m_pos) vals.push_back(0);
        end else if (run == 15 && size == 0) begin
            repeat (16) vals.push_back(0);
        end else begin
            repeat (run) vals.push_back(0);
            vals.push_back(m_ext(size, amp));
        end
        for (int i = 0; i < vals.size(); i++) begin
            if (m_pos == 63 && i < vals.size() - 1) m_err = 1;
            c.data = 12'(vals[i]);
            c.idx  = 6'(m_pos);
            c.last = (m_pos == 63);
            c.err  = m_err;
            c.cyc  = 0;
            exp_q.push_back(c);
            m_pos = (m_pos + 1) % 64;
            if (m_pos == 0) break;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        coef_t c;
        if (!rst && stall_q) begin
            check("stall_valid", coef_valid, 1);
            check("stall_data", coef_data, hold_data);
            check("stall_idx", coef_idx, hold_idx);
            check("stall_last", coef_last, hold_last);
        end
        if (!rst && coef_valid && coef_ready) begin
            c.data = coef_data;
            c.idx  = coef_idx;
            c.last = coef_last;
            c.err  = err;
            c.cyc  = cyc;
            got_q.push_back(c);
        end
        stall_q   <= !rst && coef_valid && !coef_ready;
        hold_data <= coef_data;
        hold_idx  <= coef_idx;
        hold_last <= coef_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
        coef_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send(input int run, input int size, input int amp);
        bit hs;
        int n;
        m_symbol(run, size, amp);
        sym_valid = 1'b1;
        sym_run   = 4'(run);
        sym_size  = 4'(size);
        sym_amp   = 11'(amp);
        hs = 0;
        n  = 0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = sym_ready;
            step();
            n++;
        end
        sym_valid = 1'b0;
        check("sym_accept", hs, 1);
        if (hs) check("lat_valid", coef_valid, 1);
    endtask

    task automatic wait_count(input int want);
        int n;
        n = 0;
        while (got_q.size() < want && n < 3000) begin
            step();
            n++;
        end
        check("coef_count", got_q.size(), want);
    endtask

    task automatic compare_clear();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("data[%0d]", i), got_q[i].data, exp_q[i].data);
            check($sformatf("idx[%0d]", i), got_q[i].idx, exp_q[i].idx);
            check($sformatf("last[%0d]", i), got_q[i].last, exp_q[i].last);
            check($sformatf("err[%0d]", i), got_q[i].err, exp_q[i].err);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_sym_ready", sym_ready, 0);
        rst = 1'b0;
        m_pos = 0;
        m_err = 0;
        m_pred = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int nl;
        int r;
        rst = 1'b1;
        sym_valid = 1'b0;
        sym_run = 4'd0;
        sym_size = 4'd0;
        sym_amp = 11'd0;
        coef_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sym_ready", sym_ready, 0);
        check("rst_valid", coef_valid, 0);
        check("rst_data", coef_data, 0);
        check("rst_idx", coef_idx, 0);
        check("rst_last", coef_last, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", sym_ready, 1);
        step();

        // Basic block, no backpressure: 5, 0, 0, -2, zero-fill; 64 back-to-back handshakes.
        send(0, 3, 5);
        send(2, 2, 1);
        send(0, 0, 0);
        wait_count(exp_q.size());
        if (got_q.size() == 64) begin
            check("basic_dc", got_q[0].data, 5);
            check("basic_z1", got_q[1].data, 0);
            check("basic_z2", got_q[2].data, 0);
            check("basic_ac", got_q[3].data, 32'hFFE);
            check("basic_last63", got_q[63].last, 1);
            check("basic_span", got_q[63].cyc - got_q[0].cyc, 63);
            nl = 0;
            foreach (got_q[i]) if (got_q[i].last) nl++;
            check("basic_last_count", nl, 1);
        end
        compare_clear();

        // Same block under random backpressure.
        bp = 1;
        send(0, 3, 5);
        send(2, 2, 1);
        send(0, 0, 0);
        wait_count(exp_q.size());
        compare_clear();
        bp = 0;

        // Three ZRLs then run 14 puts +1 exactly at index 63.
        send(0, 0, 0);
        repeat (3) send(15, 0, 0);
        send(14, 1, 1);
        wait_count(exp_q.size());
        if (got_q.size() == 64) begin
            check("zrl_val63", got_q[63].data, 1);
            check("zrl_idx63", got_q[63].idx, 63);
            check("zrl_last63", got_q[63].last, 1);
            check("zrl_err", got_q[63].err, 0);
        end
        compare_clear();
        send(0, 1, 1);
        send(0, 0, 0);
        wait_count(exp_q.size());
        if (got_q.size() > 0) check("zrl_next_dc_idx", got_q[0].idx, 0);
        compare_clear();

        // Run overflow: fourth run-15 symbol is cut at index 63.
        check("err_before_ovf", err, 0);
        send(0, 0, 0);
        repeat (4) send(15, 1, 0);
        wait_count(exp_q.size());
        if (got_q.size() == 64) begin
            check("ovf_val63", got_q[63].data, 0);
            check("ovf_last63", got_q[63].last, 1);
            check("ovf_err63", got_q[63].err, 1);
            check("ovf_err62", got_q[62].err, 0);
        end
        compare_clear();
        send(0, 1, 1);
        send(0, 0, 0);
        wait_count(exp_q.size());
        if (got_q.size() > 0) check("ovf_next_dc_idx", got_q[0].idx, 0);
        check("err_sticky", err, 1);
        compare_clear();

        // Random blocks under backpressure.
        bp = 1;
        for (int b = 0; b < 6; b++) begin
            send(0, $urandom_range(0, 15), $urandom_range(0, 2047));
            while (m_pos != 0) begin
                if ($urandom_range(0, 9) == 0)
                    send(0, 0, 0);
                else begin
                    r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                    send(r, $urandom_range(0, 15), $urandom_range(0, 2047));
                end
            end
            wait_count(exp_q.size());
            compare_clear();
        end
        bp = 0;

        // Reset after index 20 is taken, then a fresh DC lands at index 0.
        send(0, 0, 0);
        send(15, 0, 0);
        send(10, 1, 1);
        wait_count(21);
        rst = 1'b1;
        step();
        step();
        check("mid_rst_sym_ready", sym_ready, 0);
        rst = 1'b0;
        exp_q = exp_q[0:20];
        compare_clear();
        m_pos = 0;
        m_err = 0;
        m_pred = 0;
        check("mid_rst_err", err, 0);
        check("mid_rst_valid", coef_valid, 0);
        send(0, 1, 1);
        wait_count(1);
        if (got_q.size() > 0) begin
            check("mid_rst_dc", got_q[0].data, 1);
            check("mid_rst_idx", got_q[0].idx, 0);
            check("mid_rst_err_out", got_q[0].err, 0);
        end
        compare_clear();

        // Two blocks with DC diffs +5 then -3.
        do_reset();
        send(0, 3, 5);
        send(0, 0, 0);
        send(0, 2, 0);
        send(0, 0, 0);
        wait_count(exp_q.size());
        if (got_q.size() == 128) begin
            check("pred_dc0", got_q[0].data, 5);
`ifdef JPEG_DC_PRED_EN
            check("pred_dc1", got_q[64].data, 2);
`else
            check("pred_dc1", got_q[64].data, 32'hFFD);
`endif
        end
        compare_clear();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
